// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: reference gate codes and FSM encoding.
package gate_chk_pkg;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference gate: expected output for an input vector under the selected function.
module gate_ref_model #(
  parameter int N_IN = 2
) (
  input  logic [2:0]      gate_sel,
  input  logic [N_IN-1:0] in_vec,
  output logic            y_exp,
  output logic            sel_legal
);
  import gate_chk_pkg::*;

  // Reduction-based gate evaluation; illegal codes flag sel_legal low so every sample fails.
  always_comb begin
    y_exp     = 1'b0;
    sel_legal = 1'b1;
    case (gate_sel)
      GATE_AND:  y_exp = &in_vec;
      GATE_OR:   y_exp = |in_vec;
      GATE_NAND: y_exp = ~&in_vec;
      GATE_NOR:  y_exp = ~|in_vec;
      GATE_XOR:  y_exp = ^in_vec;
      GATE_XNOR: y_exp = ~^in_vec;
      default: begin
        y_exp     = 1'b0;
        sel_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gate_response_checker.sv
// Checks sampled gate DUT responses against a reference function; counts passes/fails,
// tracks input coverage and latches the first failing vector.
module gate_response_checker #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           gate_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 y_obs,
  input  logic                 eot,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [(1<<N_IN)-1:0] coverage,
  output logic                 first_fail_vld,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic                 done,
  output logic                 all_pass
);
  import gate_chk_pkg::*;

  localparam int              COV_W   = 1 << N_IN;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [COV_W-1:0] COV_ONE = {{(COV_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       gate_sel_r;
  logic             y_exp_s;
  logic             sel_legal_s;
  logic             accept_s;
  logic             match_s;
  logic             run_to_done_s;
  logic [COV_W-1:0] cov_bit_s;
  logic [CNT_W-1:0] pass_nxt_s;
  logic [CNT_W-1:0] fail_nxt_s;
  logic [COV_W-1:0] cov_nxt_s;
  logic             ff_vld_nxt_s;
  logic [N_IN-1:0]  ff_vec_nxt_s;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .gate_sel  (gate_sel_r),
    .in_vec    (in_vec),
    .y_exp     (y_exp_s),
    .sel_legal (sel_legal_s)
  );

  // A start in the same cycle discards the sample, since the run is being restarted.
  assign accept_s      = in_valid & in_ready & ~start;
  assign match_s       = sel_legal_s & (y_obs == y_exp_s);
  assign run_to_done_s = (state_r == ST_RUN) & ~start & eot;
  assign cov_bit_s     = COV_ONE << in_vec;

  // Next-state logic: start always (re)enters RUN and takes priority over eot.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (start)    state_s = ST_RUN;
        else if (eot) state_s = ST_DONE;
        else          state_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Result update for an accepted sample, with saturating counters.
  always_comb begin
    pass_nxt_s   = pass_cnt;
    fail_nxt_s   = fail_cnt;
    cov_nxt_s    = coverage;
    ff_vld_nxt_s = first_fail_vld;
    ff_vec_nxt_s = first_fail_vec;
    if (accept_s) begin
      cov_nxt_s = coverage | cov_bit_s;
      if (match_s) begin
        pass_nxt_s = (pass_cnt == CNT_MAX) ? pass_cnt : pass_cnt + CNT_ONE;
      end else begin
        fail_nxt_s = (fail_cnt == CNT_MAX) ? fail_cnt : fail_cnt + CNT_ONE;
        if (!first_fail_vld) begin
          ff_vld_nxt_s = 1'b1;
          ff_vec_nxt_s = in_vec;
        end else begin
          ff_vld_nxt_s = 1'b1;
          ff_vec_nxt_s = first_fail_vec;
        end
      end
    end else begin
      cov_nxt_s = coverage;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Registered results; all_pass is judged on the final counts including a same-cycle sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_sel_r     <= 3'd0;
      in_ready       <= 1'b0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
      pass_cnt       <= {CNT_W{1'b0}};
      fail_cnt       <= {CNT_W{1'b0}};
      coverage       <= {COV_W{1'b0}};
      first_fail_vld <= 1'b0;
      first_fail_vec <= {N_IN{1'b0}};
    end else begin
      in_ready <= (state_s == ST_RUN);
      done     <= (state_s == ST_DONE);
      if (start) begin
        gate_sel_r     <= gate_sel;
        all_pass       <= 1'b0;
        pass_cnt       <= {CNT_W{1'b0}};
        fail_cnt       <= {CNT_W{1'b0}};
        coverage       <= {COV_W{1'b0}};
        first_fail_vld <= 1'b0;
        first_fail_vec <= {N_IN{1'b0}};
      end else begin
        if (run_to_done_s) all_pass <= (fail_nxt_s == {CNT_W{1'b0}}) && (&cov_nxt_s);
        pass_cnt       <= pass_nxt_s;
        fail_cnt       <= fail_nxt_s;
        coverage       <= cov_nxt_s;
        first_fail_vld <= ff_vld_nxt_s;
        first_fail_vec <= ff_vec_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized and directed bench for gate_response_checker against a behavioural model.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] gate_sel = 3'd0;
  logic       in_valid = 1'b0;
  logic [1:0] in_vec = 2'd0;
  logic       y_obs = 1'b0;
  logic       eot = 1'b0;
  logic       in_ready;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;
  logic [3:0] coverage;
  logic       first_fail_vld;
  logic [1:0] first_fail_vec;
  logic       done;
  logic       all_pass;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state: 0 idle, 1 running, 2 finished.
  int m_state = 0, m_pass = 0, m_fail = 0, m_cov = 0, m_ffv = 0, m_ffvec = 0;
  int m_done = 0, m_ap = 0, m_sel = 0;

  gate_response_checker #(.N_IN(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .y_obs(y_obs),
    .eot(eot), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .coverage(coverage),
    .first_fail_vld(first_fail_vld), .first_fail_vec(first_fail_vec),
    .done(done), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  // Expected gate output from the count of ones; -1 for an illegal selector.
  function automatic int ref_y(input int sel, input logic [1:0] v);
    int ones;
    ones = $countones(v);
    case (sel)
      0: return (ones == 2) ? 1 : 0;
      1: return (ones > 0) ? 1 : 0;
      2: return (ones != 2) ? 1 : 0;
      3: return (ones == 0) ? 1 : 0;
      4: return ones % 2;
      5: return 1 - (ones % 2);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pass = 0; m_fail = 0; m_cov = 0; m_ffv = 0; m_ffvec = 0;
    m_done = 0; m_ap = 0; m_sel = 0;
  endtask

  // Model update on each clock edge and immediately on reset.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      model_reset();
    end else if (start) begin
      m_state = 1; m_pass = 0; m_fail = 0; m_cov = 0; m_ffv = 0; m_ffvec = 0;
      m_done = 0; m_ap = 0; m_sel = gate_sel;
    end else if (m_state == 1) begin
      if (in_valid) begin
        int e;
        e = ref_y(m_sel, in_vec);
        if (e >= 0 && e == int'(y_obs)) m_pass = (m_pass < 255) ? m_pass + 1 : 255;
        else begin
          m_fail = (m_fail < 255) ? m_fail + 1 : 255;
          if (m_ffv == 0) begin m_ffv = 1; m_ffvec = in_vec; end
        end
        m_cov = m_cov | (1 << in_vec);
      end
      if (eot) begin
        m_state = 2; m_done = 1;
        m_ap = (m_fail == 0 && m_cov == 15) ? 1 : 0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", in_ready, (m_state == 1) ? 1 : 0);
      chk("pass_cnt", pass_cnt, m_pass);
      chk("fail_cnt", fail_cnt, m_fail);
      chk("coverage", coverage, m_cov);
      chk("first_fail_vld", first_fail_vld, m_ffv);
      chk("first_fail_vec", first_fail_vec, m_ffvec);
      chk("done", done, m_done);
      chk("all_pass", all_pass, m_ap);
    end
  end

  task automatic cyc(input bit s, input int sel, input bit v, input int vec, input bit y, input bit e);
    @(negedge clk);
    start = s; gate_sel = sel[2:0]; in_valid = v; in_vec = vec[1:0]; y_obs = y; eot = e;
  endtask

  task automatic idle(input int sel);
    cyc(1'b0, sel, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset in_ready", in_ready, 0);
    chk("reset done", done, 0);

    // 1: AND, all correct
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 1, 1, 0, 0); cyc(0, 0, 1, 2, 0, 0); cyc(0, 0, 1, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); idle(0);
    chk("t1 pass", pass_cnt, 4); chk("t1 fail", fail_cnt, 0);
    chk("t1 cov", coverage, 15); chk("t1 done", done, 1); chk("t1 all_pass", all_pass, 1);

    // 2: AND, 01 answered wrongly
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 1, 1, 1, 0); cyc(0, 0, 1, 2, 0, 0); cyc(0, 0, 1, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); idle(0);
    chk("t2 pass", pass_cnt, 3); chk("t2 fail", fail_cnt, 1);
    chk("t2 ffvec", first_fail_vec, 1); chk("t2 all_pass", all_pass, 0);

    // 3: XOR, partial coverage; gate_sel changes mid-run must be ignored
    cyc(1, 4, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0); cyc(0, 1, 1, 2, 1, 0); cyc(0, 0, 0, 0, 0, 1); idle(0);
    chk("t3 fail", fail_cnt, 0); chk("t3 cov", coverage, 6); chk("t3 all_pass", all_pass, 0);

    // 4: pass counter saturation
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); idle(0);
    chk("t4 pass sat", pass_cnt, 255); chk("t4 fail", fail_cnt, 0);

    // 5: sample with eot counted; later start with valid drops the sample
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3, 1, 1); idle(0);
    chk("t5 pass", pass_cnt, 1); chk("t5 done", done, 1); chk("t5 all_pass", all_pass, 0);
    cyc(1, 0, 1, 0, 0, 0); cyc(1, 0, 1, 3, 1, 0); idle(0);
    chk("t5 restart pass", pass_cnt, 0); chk("t5 restart cov", coverage, 0);
    chk("t5 ready", in_ready, 1);

    // 6: asynchronous reset mid-run
    cyc(0, 0, 1, 3, 1, 0); cyc(0, 0, 1, 0, 1, 0); idle(0);
    chk("t6 pre pass", pass_cnt, 1); chk("t6 pre fail", fail_cnt, 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("t6 rst pass", pass_cnt, 0); chk("t6 rst fail", fail_cnt, 0);
    chk("t6 rst cov", coverage, 0); chk("t6 rst ffv", first_fail_vld, 0);
    chk("t6 rst ready", in_ready, 0);
    #3 rst = 1'b0;
    cyc(0, 0, 1, 3, 1, 0); cyc(0, 0, 1, 3, 1, 0); idle(0);
    chk("t6 post ready", in_ready, 0); chk("t6 post pass", pass_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int sel, vec, e;
      bit s, v, y, eo;
      s   = ($urandom_range(0, 99) < 4);
      sel = ($urandom_range(0, 99) < 90) ? $urandom_range(0, 5) : $urandom_range(6, 7);
      v   = ($urandom_range(0, 99) < 70);
      vec = $urandom_range(0, 3);
      e   = ref_y(m_sel, vec[1:0]);
      y   = (e >= 0 && $urandom_range(0, 99) < 80) ? e[0] : 1'($urandom_range(0, 1));
      eo  = ($urandom_range(0, 99) < 5);
      cyc(s, sel, v, vec, y, eo);
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    idle(0); idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
